// File: rtl/sound_cmd_mailbox.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sound_cmd_mailbox : 68000 <-> 6502 command FIFO, reply register, NMI/IRQ.
// Revision 1.0
// ---------------------------------------------------------------------------
module sound_cmd_mailbox #(
   parameter int DEPTH     = 4,
   parameter int NMI_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       main_wr_l,
   input  logic                       main_rd_l,
   input  logic [7:0]                 main_din,
   output logic [7:0]                 main_dout,
   output logic                       main_irq_l,
   input  logic                       status_clr,
   input  logic                       WR68k_l,
   input  logic                       RD68k_l,
   input  logic [7:0]                 snd_din,
   output logic [7:0]                 snd_dout,
   output logic                       snd_nmi_l,
   output logic [$clog2(DEPTH):0]     cmd_count,
   output logic                       cmd_full,
   output logic                       reply_full,
   output logic                       cmd_ovr,
   output logic                       reply_ovr
);

   localparam int c_aw  = $clog2(DEPTH);
   localparam int c_cw  = c_aw + 1;
   localparam int c_ncw = $clog2(NMI_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_GAP   = 2'd2
   } nmi_state_t;

   logic [7:0]       r_mem [DEPTH];
   logic [c_aw-1:0]  r_wp, r_rp;
   logic [c_cw-1:0]  r_count;
   logic             r_mwr_prev, r_mrd_prev, r_swr_prev, r_srd_prev;
   logic [7:0]       r_reply;
   logic             r_reply_full, r_cmd_ovr, r_reply_ovr;
   nmi_state_t       r_state;
   logic [c_ncw-1:0] r_ncnt;
   logic             r_pend, r_nmi_l;

   logic w_push_ev, w_pop_ev, w_swr_ev, w_mrd_ev;
   logic w_full, w_empty, w_pop_ok, w_push_ok;

   assign w_push_ev = ~main_wr_l & r_mwr_prev;
   assign w_mrd_ev  = ~main_rd_l & r_mrd_prev;
   assign w_swr_ev  = ~WR68k_l   & r_swr_prev;
   assign w_pop_ev  = ~RD68k_l   & r_srd_prev;

   assign w_full    = (r_count == c_cw'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_pop_ok  = w_pop_ev & ~w_empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_push_ok = w_push_ev & (~w_full | w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok && !rst) begin
         r_mem[r_wp] <= main_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp         <= '0;
         r_rp         <= '0;
         r_count      <= '0;
         r_mwr_prev   <= 1'b1;
         r_mrd_prev   <= 1'b1;
         r_swr_prev   <= 1'b1;
         r_srd_prev   <= 1'b1;
         r_reply      <= 8'h00;
         r_reply_full <= 1'b0;
         r_cmd_ovr    <= 1'b0;
         r_reply_ovr  <= 1'b0;
      end else begin
         r_mwr_prev <= main_wr_l;
         r_mrd_prev <= main_rd_l;
         r_swr_prev <= WR68k_l;
         r_srd_prev <= RD68k_l;
         if (w_push_ok) r_wp <= r_wp + c_aw'(1);
         if (w_pop_ok)  r_rp <= r_rp + c_aw'(1);
         r_count <= r_count + c_cw'(w_push_ok) - c_cw'(w_pop_ok);

         if (w_swr_ev) begin
            r_reply      <= snd_din;
            r_reply_full <= 1'b1;
         end else if (w_mrd_ev) begin
            r_reply_full <= 1'b0;
         end

         // Setting a sticky flag takes priority over a coincident clear.
         if (w_push_ev && !w_push_ok)                  r_cmd_ovr <= 1'b1;
         else if (status_clr)                          r_cmd_ovr <= 1'b0;
         if (w_swr_ev && r_reply_full && !w_mrd_ev)    r_reply_ovr <= 1'b1;
         else if (status_clr)                          r_reply_ovr <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ncnt  <= '0;
         r_pend  <= 1'b0;
         r_nmi_l <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_push_ok) begin
                  r_state <= S_PULSE;
                  r_ncnt  <= c_ncw'(NMI_WIDTH - 1);
                  r_nmi_l <= 1'b0;
               end
            end
            S_PULSE: begin
               if (w_push_ok) r_pend <= 1'b1;
               if (r_ncnt == '0) begin
                  r_state <= S_GAP;
                  r_nmi_l <= 1'b1;
               end else begin
                  r_ncnt <= r_ncnt - c_ncw'(1);
               end
            end
            S_GAP: begin
               // Any push seen here merges with the pending request.
               if (r_pend || w_push_ok) begin
                  r_state <= S_PULSE;
                  r_ncnt  <= c_ncw'(NMI_WIDTH - 1);
                  r_nmi_l <= 1'b0;
                  r_pend  <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_nmi_l <= 1'b1;
            end
         endcase
      end
   end

   assign snd_dout   = w_empty ? 8'hFF : r_mem[r_rp];
   assign snd_nmi_l  = r_nmi_l;
   assign cmd_count  = r_count;
   assign cmd_full   = w_full;
   assign cmd_ovr    = r_cmd_ovr;
   assign main_dout  = r_reply;
   assign reply_full = r_reply_full;
   assign main_irq_l = ~r_reply_full;
   assign reply_ovr  = r_reply_ovr;

endmodule
`default_nettype wire

// File: doc/sound_cmd_mailbox.md
Name: sound_cmd_mailbox

Overview:
- Bidirectional command/reply mailbox between the 68000 main CPU and the 6502 sound CPU on the sound board.
- It sequences the sound-side strobes WR68k_l and RD68k_l produced by the sound address decoder. It buffers main-to-sound commands in a small FIFO and holds sound-to-main replies in a single register.
- It generates the sound CPU NMI pulse and the main CPU interrupt, and reports overrun conditions.

Parameters:
- DEPTH, 4, command FIFO depth in bytes; power of two, 2..16.
- NMI_WIDTH, 8, clocks that snd_nmi_l is held low per pulse; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- main_wr_l  input  1  main CPU command-write strobe, active-low level.
- main_rd_l  input  1  main CPU reply-read strobe, active-low level.
- main_din  input  8  command byte from the main CPU.
- main_dout  output  8  reply register contents.
- main_irq_l  output  1  low while a reply is pending.
- status_clr  input  1  one-cycle pulse; clears cmd_ovr and reply_ovr.
- WR68k_l  input  1  sound CPU reply-write strobe from the decoder, active-low level.
- RD68k_l  input  1  sound CPU command-read strobe from the decoder, active-low level.
- snd_din  input  8  reply byte from the sound CPU.
- snd_dout  output  8  FIFO head byte; 8'hFF when the FIFO is empty.
- snd_nmi_l  output  1  NMI pulse to the 6502, active-low.
- cmd_count  output  $clog2(DEPTH)+1  number of bytes in the FIFO.
- cmd_full  output  1  FIFO holds DEPTH bytes.
- reply_full  output  1  reply is unread.
- cmd_ovr  output  1  sticky; a command was dropped.
- reply_ovr  output  1  sticky; an unread reply was overwritten.

Behaviour:
- Strobe edge detection:
  - Each of the four strobes has a "previous" register that resets to 1.
  - An event occurs on the rising clk edge where the strobe is sampled 0 and its previous value is 1.
  - Data (main_din/snd_din) is captured on that same edge.
  - A strobe held low for many cycles produces exactly one event.
- Command FIFO (circular buffer):
  - Push event (main_wr_l): if not full, write mem[wp], wp++, count++. If full, drop the byte and set cmd_ovr.
  - Pop event (RD68k_l): if count>0, rp++ and count--. If empty, the event is ignored with no error.
  - Push and pop on the same edge, FIFO full: both succeed; count unchanged; no overrun.
  - Push and pop on the same edge, FIFO empty: the pop is ignored; the push succeeds; count becomes 1.
  - Pointers wrap modulo DEPTH.
  - snd_dout = mem[rp] when count>0, else 8'hFF. It is combinational from registered state, so a new head is visible the cycle after a pop.
- NMI sequencer, states IDLE, PULSE, GAP:
  - IDLE -> PULSE on any successful push; snd_nmi_l goes low the next cycle.
  - PULSE holds snd_nmi_l low for NMI_WIDTH cycles via a down-counter, then moves to GAP.
  - GAP drives snd_nmi_l high for exactly 1 cycle. It then enters PULSE if the pend flag is set (clearing pend), otherwise IDLE.
  - A successful push while in PULSE or GAP sets the 1-bit pend flag. Multiple such pushes still yield one extra pulse.
- Reply register:
  - WR68k_l event: reply <= snd_din and reply_full <= 1. If reply_full was already 1 and there is no simultaneous main_rd_l event, set reply_ovr.
  - main_rd_l event: reply_full <= 0.
  - Both events on the same edge: the write wins; reply_full stays 1 with the new data; reply_ovr is not set.
  - main_dout = reply at all times. main_irq_l = ~reply_full.
- Sticky flags:
  - status_clr clears cmd_ovr and reply_ovr.
  - If status_clr coincides with a new overrun, the set wins.
- Reset (rst high on a clk edge):
  - wp, rp, count = 0; pend = 0; NMI state = IDLE.
  - reply = 8'h00; reply_full, cmd_ovr, reply_ovr = 0; strobe-previous registers = 1.
  - Resulting outputs: snd_nmi_l = 1, main_irq_l = 1, snd_dout = 8'hFF, main_dout = 8'h00.
  - Reset mid-pulse forces snd_nmi_l high on the next cycle.
  - FIFO memory contents need not be reset.

Test Plan:
- Reset, then a main_wr_l pulse with main_din=8'h3C -> cmd_count=1, snd_dout=8'h3C, snd_nmi_l low for exactly 8 cycles, then high.
- 5 pushes of 8'h01..8'h05 with DEPTH=4 -> cmd_full=1, cmd_ovr=1; 4 RD68k_l pops yield 8'h01..8'h04, then snd_dout=8'hFF; status_clr -> cmd_ovr=0.
- Second push during an active NMI pulse -> after 8 low cycles, 1 high cycle, then a second 8-cycle low pulse; a third push in GAP produces no third pulse.
- WR68k_l with snd_din=8'hA5 -> main_irq_l=0, main_dout=8'hA5; second WR68k_l with 8'h5A before main read -> reply_ovr=1, main_dout=8'h5A; main_rd_l -> main_irq_l=1.
- FIFO full with push and pop on the same edge -> count stays 4, cmd_ovr stays 0; empty FIFO with both on the same edge -> count=1. Strobe held low for 20 cycles -> one event only.
- rst asserted for 1 cycle mid-NMI pulse with count=3 -> next cycle snd_nmi_l=1, cmd_count=0, reply_full=0, snd_dout=8'hFF.
